// File: rtl/dbus_responder_if.sv
// Bus and TX-stream signal bundle for dbus_responder.
// tx_valid/tx_ready: a byte transfers at the posedge where both are high; tx_valid never depends on tx_ready.
interface dbus_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_data_in;
  logic             bus_we;
  logic             bus_re;
  logic [3:0]       bus_byteen;
  logic [WIDTH-1:0] bus_data_out;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             bus_err;

  modport master (
    output bus_addr, bus_data_in, bus_we, bus_re, bus_byteen, tx_ready,
    input  bus_data_out, tx_data, tx_valid, bus_err
  );

  modport slave (
    input  bus_addr, bus_data_in, bus_we, bus_re, bus_byteen, tx_ready,
    output bus_data_out, tx_data, tx_valid, bus_err
  );
endinterface

// File: rtl/dbus_responder.sv
// Zero-wait-state bus target: word RAM, TX byte FIFO with status, sticky unmapped-access flag.
// Optional 64-bit free-running timer at TIMER_LO/TIMER_HI when DBUS_TIMER_EN is defined.
module dbus_responder #(
  parameter int WIDTH      = 32,
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  dbus_responder_if.slave bus
);
  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [WIDTH-1:0] MMIO_BASE = WIDTH'(32'h1000_0000);

  logic [WIDTH-1:0] r_ram [RAM_WORDS];
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_bus_err;

  logic             w_ram_sel, w_mmio_blk, w_mapped;
  logic             w_sel_txdata, w_sel_txstat, w_sel_tlo, w_sel_thi;
  logic [1:0]       w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [WIDTH-1:0] w_wmask, w_rdata, w_txstat;
  logic [3:0]       w_cnt_field;
  logic             w_empty, w_full, w_pop, w_push_req, w_push, w_ovf_set, w_ovf_clr;
  logic             w_unused;

  assign w_unused     = &{1'b0, bus.bus_addr[1:0]};
  assign w_ram_sel    = (bus.bus_addr[WIDTH-1:RAM_AW+2] == '0);
  assign w_mmio_blk   = (bus.bus_addr[WIDTH-1:4] == MMIO_BASE[WIDTH-1:4]);
  assign w_off        = bus.bus_addr[3:2];
  assign w_ram_idx    = bus.bus_addr[RAM_AW+1:2];
  assign w_sel_txdata = w_mmio_blk && (w_off == 2'd0);
  assign w_sel_txstat = w_mmio_blk && (w_off == 2'd1);
`ifdef DBUS_TIMER_EN
  assign w_sel_tlo    = w_mmio_blk && (w_off == 2'd2);
  assign w_sel_thi    = w_mmio_blk && (w_off == 2'd3);
`else
  assign w_sel_tlo    = 1'b0;
  assign w_sel_thi    = 1'b0;
`endif
  assign w_mapped = w_ram_sel | w_sel_txdata | w_sel_txstat | w_sel_tlo | w_sel_thi;

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < 4; i++) w_wmask[8*i +: 8] = {8{bus.bus_byteen[i]}};
  end

  // FIFO control: a push into a full FIFO is accepted only when a pop frees the head slot.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = !w_empty && bus.tx_ready;
  assign w_push_req = bus.bus_we && w_sel_txdata && bus.bus_byteen[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = bus.bus_we && w_sel_txstat && bus.bus_byteen[0] && bus.bus_data_in[2];

  always_comb begin
    w_cnt_field = (int'(r_count) > 15) ? 4'hF : 4'(r_count);
    w_txstat    = '0;
    w_txstat[7:4] = w_cnt_field;
    w_txstat[2]   = r_ovf;
    w_txstat[1]   = w_empty;
    w_txstat[0]   = w_full;
  end

  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign bus.bus_err  = r_bus_err;

  always_ff @(posedge clk) begin
    if (!reset && bus.bus_we && w_ram_sel)
      r_ram[w_ram_idx] <= (r_ram[w_ram_idx] & ~w_wmask) | (bus.bus_data_in & w_wmask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= bus.bus_data_in[7:0];
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if ((bus.bus_re || bus.bus_we) && !w_mapped) r_bus_err <= 1'b1;
    end
  end

`ifdef DBUS_TIMER_EN
  logic [63:0] r_timer;
  logic [31:0] r_shadow;

  // A write to either half replaces that half and suppresses the increment for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer  <= '0;
      r_shadow <= '0;
    end else begin
      if (bus.bus_we && w_sel_tlo)
        r_timer[31:0] <= (r_timer[31:0] & ~w_wmask[31:0]) | (bus.bus_data_in[31:0] & w_wmask[31:0]);
      else if (bus.bus_we && w_sel_thi)
        r_timer[63:32] <= (r_timer[63:32] & ~w_wmask[31:0]) | (bus.bus_data_in[31:0] & w_wmask[31:0]);
      else
        r_timer <= r_timer + 64'd1;
      if (bus.bus_re && w_sel_tlo) r_shadow <= r_timer[63:32];
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (bus.bus_re) begin
      if (w_ram_sel)         w_rdata = r_ram[w_ram_idx];
      else if (w_sel_txstat) w_rdata = w_txstat;
`ifdef DBUS_TIMER_EN
      else if (w_sel_tlo)    w_rdata = WIDTH'(r_timer[31:0]);
      else if (w_sel_thi)    w_rdata = WIDTH'(r_shadow);
`endif
    end
  end

  assign bus.bus_data_out = w_rdata;
endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: read data and TX bytes are checked against expected queues by a monitor.
module tb_dbus_responder;
  localparam logic [31:0] A_TXDATA = 32'h1000_0000;
  localparam logic [31:0] A_TXSTAT = 32'h1000_0004;
  localparam logic [31:0] A_TLO    = 32'h1000_0008;
  localparam logic [31:0] A_THI    = 32'h1000_000C;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];

  dbus_responder_if #(.WIDTH(32)) bif ();

  dbus_responder #(.WIDTH(32), .RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks: each starts just after a posedge and ends #1 after the next one
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bif.bus_addr = a; bif.bus_data_in = d; bif.bus_byteen = be; bif.bus_we = 1'b1;
    @(posedge clk); #1;
    bif.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    bif.bus_addr = a; bif.bus_re = 1'b1;
    @(posedge clk); #1;
    bif.bus_re = 1'b0;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] exp);
    exp_q.push_back(exp);
    bif.bus_addr = a; bif.bus_data_in = d; bif.bus_byteen = be;
    bif.bus_we = 1'b1; bif.bus_re = 1'b1;
    @(posedge clk); #1;
    bif.bus_we = 1'b0; bif.bus_re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bif.bus_re) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", bif.bus_data_out);
      end else chk("rd_data", bif.bus_data_out, exp_q.pop_front());
    end
    if (bif.tx_valid && bif.tx_ready) begin
      if (exp_tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got 0x%02h expected no byte", bif.tx_data);
      end else chk("tx_byte", {24'h0, bif.tx_data}, {24'h0, exp_tx_q.pop_front()});
    end
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bif.bus_addr = '0; bif.bus_data_in = '0; bif.bus_byteen = '0;
    bif.bus_we = 1'b0; bif.bus_re = 1'b0; bif.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_tx_valid", {31'h0, bif.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, bif.tx_data}, 32'h0);
    chk("rst_bus_err", {31'h0, bif.bus_err}, 32'h0);
    chk("idle_rdata_zero", bif.bus_data_out, 32'h0);
    bus_read(A_TXSTAT, 32'h0000_0002);

    // RAM byte lanes, ignored low address bits, read-during-write
    bus_write(32'h10, 32'hAABB_CCDD, 4'hF);
    bus_write(32'h10, 32'h0000_1100, 4'b0010);
    bus_read(32'h10, 32'hAABB_11DD);
    bus_read(32'h13, 32'hAABB_11DD);
    bus_write(32'h14, 32'h1234_5678, 4'hF);
    bus_rw(32'h14, 32'h8765_4321, 4'hF, 32'h1234_5678);
    bus_read(32'h14, 32'h8765_4321);
    bus_write(32'hFFC, 32'h5555_AAAA, 4'b1001);
    bus_write(32'hFFC, 32'h0123_4567, 4'b0110);
    bus_read(32'hFFC, 32'h5523_45AA);

    // FIFO fill and overflow
    bus_write(A_TXDATA, 32'h0000_0077, 4'b1110);
    chk("no_push_without_lane0", {31'h0, bif.tx_valid}, 32'h0);
    bus_write(A_TXDATA, 32'hCAFE_0001, 4'b0001);
    chk("push_latency_valid", {31'h0, bif.tx_valid}, 32'h1);
    exp_tx_q.push_back(8'h01);
    for (int i = 2; i <= 9; i++) begin
      bus_write(A_TXDATA, 32'hCAFE_0000 | i, 4'b0001);
      if (i <= 8) exp_tx_q.push_back(8'(i));
    end
    bus_read(A_TXSTAT, 32'h0000_0085);
    chk("full_head", {24'h0, bif.tx_data}, 32'h01);
    bus_read(A_TXDATA, 32'h0);

    // simultaneous pop and push on full FIFO
    bif.tx_ready = 1'b1;
    bus_write(A_TXDATA, 32'h0000_005A, 4'b0001);
    bif.tx_ready = 1'b0;
    exp_tx_q.push_back(8'h5A);
    bus_read(A_TXSTAT, 32'h0000_0085);
    bus_write(A_TXSTAT, 32'h0000_0004, 4'b0001);
    bus_read(A_TXSTAT, 32'h0000_0081);
    bif.tx_ready = 1'b1;
    idle(8);
    bif.tx_ready = 1'b0;
    bus_read(A_TXSTAT, 32'h0000_0002);
    chk("tx_q_drained", exp_tx_q.size(), 32'h0);

    // unmapped accesses and sticky error
    chk("err_before_unmapped", {31'h0, bif.bus_err}, 32'h0);
    bus_read(32'h2000_0000, 32'h0);
    chk("err_after_unmapped", {31'h0, bif.bus_err}, 32'h1);
    bus_write(32'h0, 32'h1111_1111, 4'hF);
    bus_write(32'h1000, 32'hDEAD_BEEF, 4'hF);
    bus_read(32'h0, 32'h1111_1111);
    bus_read(32'h1000_0010, 32'h0);
    idle(3);
    chk("err_sticky", {31'h0, bif.bus_err}, 32'h1);

    // reset with queued bytes and a concurrent push
    for (int i = 0; i < 3; i++) bus_write(A_TXDATA, 32'h40 + i, 4'b0001);
    chk("queued_valid", {31'h0, bif.tx_valid}, 32'h1);
    reset = 1'b1;
    bif.bus_addr = A_TXDATA; bif.bus_data_in = 32'h99; bif.bus_byteen = 4'b0001; bif.bus_we = 1'b1;
    @(posedge clk); #1;
    bif.bus_we = 1'b0;
    reset = 1'b0;
    chk("rst2_tx_valid", {31'h0, bif.tx_valid}, 32'h0);
    chk("rst2_tx_data", {24'h0, bif.tx_data}, 32'h0);
    chk("rst2_bus_err", {31'h0, bif.bus_err}, 32'h0);
    bus_read(A_TXSTAT, 32'h0000_0002);
    chk("rst2_still_empty", {31'h0, bif.tx_valid}, 32'h0);
    bus_read(32'h10, 32'hAABB_11DD);

`ifdef DBUS_TIMER_EN
    bus_write(A_TLO, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_THI, 32'h0, 4'hF);
    idle(3);
    bus_read(A_TLO, 32'h0000_0001);
    bus_read(A_THI, 32'h0000_0001);
    chk("timer_no_err", {31'h0, bif.bus_err}, 32'h0);
`else
    bus_read(A_TLO, 32'h0);
    chk("timer_unmapped_err", {31'h0, bif.bus_err}, 32'h1);
    bus_read(A_THI, 32'h0);
`endif

    idle(2);
    chk("rd_q_drained", exp_q.size(), 32'h0);
    chk("tx_q_empty_end", exp_tx_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
